// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: turns hazard stall, mispredict and data-memory wait into
// per-stage load enables / flush strobes, with start-up flush, wait timeout and perf counters.
module pipe_sequencer #(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        HazStall,
    input  logic        MP,
    input  logic        MemReq,
    input  logic        MemReady,
    input  logic        CntClr,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXWrite,
    output logic        IDEXFlush,
    output logic        EXMEMWrite,
    output logic        MemErr,
    output logic [2:0]  State,
    output logic [15:0] StallCnt,
    output logic [7:0]  FlushCnt
);

    localparam int unsigned INIT_W  = 4;
    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned STALL_W = 16;
    localparam int unsigned FLUSH_W = 8;
    localparam int unsigned CTRL_W  = 6;

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_RUN     = 3'd1,
        S_STALL   = 3'd2,
        S_FLUSH   = 3'd3,
        S_MEMWAIT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mp_pend_q, mp_pend_d;
    logic                mem_err_d;
    logic [STALL_W-1:0]  stall_cnt_d;
    logic [FLUSH_W-1:0]  flush_cnt_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic                mp_seen;

    // Next-state, bookkeeping and registered-output decode
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        mp_pend_d   = mp_pend_q;
        mem_err_d   = MemErr;
        stall_cnt_d = StallCnt;
        flush_cnt_d = FlushCnt;
        ctrl_d      = '0;
        mp_seen     = mp_pend_q | MP;

        case (state_q)
            S_INIT: begin
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            S_RUN, S_STALL, S_FLUSH: begin
                if (MemReq && !MemReady) begin
                    state_d    = S_MEMWAIT;
                    wait_cnt_d = '0;
                    mp_pend_d  = 1'b0;
                end else if (MP && (state_q != S_FLUSH)) begin
                    state_d = S_FLUSH;
                end else if (HazStall) begin
                    state_d = S_STALL;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_MEMWAIT: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                mp_pend_d  = mp_seen;
                if (MemReady || (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1))) begin
                    // A ready in the last allowed cycle still counts as a normal completion
                    if (!MemReady) begin
                        mem_err_d = 1'b1;
                    end
                    if (mp_seen) begin
                        state_d   = S_FLUSH;
                        mp_pend_d = 1'b0;
                    end else if (HazStall) begin
                        state_d = S_STALL;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase

        // {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMWrite}
        case (state_d)
            S_INIT:    ctrl_d = 6'b001111;
            S_RUN:     ctrl_d = 6'b110101;
            S_STALL:   ctrl_d = 6'b000111;
            S_FLUSH:   ctrl_d = 6'b111111;
            S_MEMWAIT: ctrl_d = 6'b000000;
            default:   ctrl_d = 6'b001111;
        endcase

        if (CntClr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (((state_q == S_STALL) || (state_q == S_MEMWAIT)) && (StallCnt != '1)) begin
                stall_cnt_d = StallCnt + STALL_W'(1);
            end
            if ((state_d == S_FLUSH) && (state_q != S_FLUSH) && (FlushCnt != '1)) begin
                flush_cnt_d = FlushCnt + FLUSH_W'(1);
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            wait_cnt_q <= '0;
            mp_pend_q  <= 1'b0;
            MemErr     <= 1'b0;
            StallCnt   <= '0;
            FlushCnt   <= '0;
            ctrl_q     <= 6'b001111;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mp_pend_q  <= mp_pend_d;
            MemErr     <= mem_err_d;
            StallCnt   <= stall_cnt_d;
            FlushCnt   <= flush_cnt_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMWrite} = ctrl_q;
    assign State = 3'(state_q);

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Pipeline sequencer for the 16-bit, 4-stage (IF/ID/EX/MEM) pipelined CPU. It converts the raw hazard stall request, the branch-mispredict flag and the data-memory wait handshake into per-stage register enables and flush strobes for the PC, IF/ID, ID/EX and EX/MEM registers. It also runs start-up flush, memory-wait timeout detection and stall/flush performance counters. It sits between the hazard controller and the pipeline registers, replacing direct use of the stall signal as a PC hold.

## Interface
- INIT_CYCLES, 2: cycles spent in INIT after reset; legal range 1–15.
- MEM_TIMEOUT, 15: maximum MEMWAIT cycles before forced exit; legal range 1–255.

- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- HazStall  in  1  data-hazard stall request from the hazard controller.
- MP  in  1  branch misprediction flag.
- MemReq  in  1  the EX/MEM instruction accesses data memory this cycle.
- MemReady  in  1  data memory has completed the access.
- CntClr  in  1  synchronous clear of StallCnt and FlushCnt.
- PCWrite  out  1  PC load enable.
- IFIDWrite  out  1  IF/ID load enable.
- IFIDFlush  out  1  IF/ID loads 16'h0000 (NOP); overrides IFIDWrite.
- IDEXWrite  out  1  ID/EX load enable.
- IDEXFlush  out  1  ID/EX loads a bubble (control bits zero); overrides IDEXWrite.
- EXMEMWrite  out  1  EX/MEM load enable.
- MemErr  out  1  sticky flag for memory timeout; cleared only by reset.
- State  out  3  current state: INIT=0, RUN=1, STALL=2, FLUSH=3, MEMWAIT=4.
- StallCnt  out  16  number of cycles spent in STALL or MEMWAIT; saturates at 16'hFFFF.
- FlushCnt  out  8  number of entries into FLUSH; saturates at 8'hFF.

## Operation
- Outputs are a Moore decode of State only. Values are listed as PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMWrite:
  - INIT: 0,0,1,1,1,1
  - RUN: 1,1,0,1,0,1
  - STALL: 0,0,0,1,1,1 (holds PC and IF/ID, inserts a bubble into ID/EX)
  - FLUSH: 1,1,1,1,1,1 (fetches the corrected target, kills IF/ID and ID/EX)
  - MEMWAIT: 0,0,0,0,0,0 (freezes the whole pipe)
- INIT: InitCnt counts from 0. The state moves to RUN after the cycle in which InitCnt == INIT_CYCLES-1. Inputs are ignored in INIT.
- From RUN, STALL or FLUSH, the next state is chosen by priority, highest first:
  1. MemReq & !MemReady → MEMWAIT
  2. MP → FLUSH (MP is ignored while already in FLUSH)
  3. HazStall → STALL
  4. otherwise → RUN
- MemReq & MemReady in the same cycle causes no wait.
- MP and HazStall asserted together → FLUSH, because the stalled instruction is on the wrong path.
- MEMWAIT:
  - WaitCnt (8 bit) is cleared on entry and increments once per MEMWAIT cycle.
  - Exit occurs after a cycle in which MemReady=1, or in which WaitCnt == MEM_TIMEOUT-1. A timeout exit also sets MemErr.
  - MP asserted during MEMWAIT sets MPPend. On exit, the next state is FLUSH if MPPend=1 (MPPend is then cleared). Otherwise it is STALL if HazStall=1, else RUN.
- Counters:
  - StallCnt increments in every cycle where State is STALL or MEMWAIT.
  - FlushCnt increments on every transition into FLUSH.
  - Both counters saturate.
  - CntClr zeroes both counters and takes precedence over an increment in the same cycle.
- reset, including mid-operation: State=INIT, InitCnt=0, WaitCnt=0, MPPend=0, MemErr=0, StallCnt=0, FlushCnt=0.

## Timing
- Latency is exactly 1 cycle from an input sampled at edge N to the changed enables during cycle N+1. There is no combinational path from any input to any output.
- FLUSH always lasts exactly 1 cycle.
- STALL lasts for as many cycles as HazStall remains high.
- After reset deasserts, INIT occupies INIT_CYCLES cycles. PCWrite first rises in cycle INIT_CYCLES+1.
- The maximum MEMWAIT duration is MEM_TIMEOUT cycles.
- MemErr rises in the cycle after the timeout cycle.
- Reset values of outputs follow the INIT decode: PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXWrite=1, IDEXFlush=1, EXMEMWrite=1, MemErr=0, State=0, StallCnt=0, FlushCnt=0.

## Test plan
- Reset for 3 cycles, then release with INIT_CYCLES=2 and all inputs 0 → State 0,0,1. PCWrite=1 from the 3rd cycle after release.
- In RUN, hold HazStall=1 for 3 cycles → State=2 for 3 cycles with PCWrite=0 and IDEXFlush=1. State returns to 1. StallCnt=3.
- In RUN, assert MP and HazStall together for 1 cycle → one FLUSH cycle with IFIDFlush=IDEXFlush=1, then RUN. FlushCnt=1, StallCnt unchanged.
- Hold MemReq=1 with MemReady=0; pulse MP on the 2nd wait cycle; raise MemReady on the 4th → 4 MEMWAIT cycles with all enables 0, then FLUSH, then RUN. MemErr=0.
- With MEM_TIMEOUT=15, hold MemReq=1 and MemReady=0 → exactly 15 MEMWAIT cycles, then RUN. MemErr=1, and it stays 1 until reset.
- Preload StallCnt to 16'hFFFF via a long stall, then stall one more cycle → value stays FFFF. Assert CntClr during a stall cycle → StallCnt=0.
